uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serial transmitter feeding FPGA_SERIAL_TX on the Riscv151 top level; counterpart of the CPU's UART receiver on FPGA_SERIAL_RX.
- Accepts bytes from the CPU's memory-mapped UART write path over a valid/ready handshake.
- Buffers bytes in a small FIFO.
- Serialises each byte as an 8N1 frame (start 0, 8 data bits LSB first, stop 1) at BAUD_RATE.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- FIFO_DEPTH, 4, byte slots in the input buffer; power of two, >= 2.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  producer offers data_in this cycle.
- data_in_ready  output  1  FIFO can accept; high when FIFO not full.
- serial_out  output  1  line to FPGA_SERIAL_TX; idle high.
- tx_busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Bit period: N = CLOCK_FREQ / BAUD_RATE, integer division (434 at defaults).
  - Baud counter width is clog2(N).
  - Counter counts 0..N-1, then wraps.
  - Every bit, including start and stop, holds serial_out for exactly N cycles. Frame = 10*N cycles.
- Reset (rst_n low, asynchronous):
  - serial_out=1, FSM=IDLE, FIFO emptied, counters 0.
  - data_in_ready=1; pushes while rst_n is low are ignored.
  - tx_busy=0.
  - Reset mid-frame aborts the frame immediately: line goes high with no glitch low, and queued bytes are lost.
- Handshake:
  - A push occurs on a rising edge with data_in_valid && data_in_ready.
  - data_in_ready is a registered-state function (!full) only; it never depends on data_in_valid.
  - Producer must hold data_in/valid until accepted.
  - No push when full. Full plus pop in the same cycle: ready rises the next cycle.
- FIFO: circular, read/write pointers with one extra wrap bit.
  - full when the pointers differ only in the MSB; empty when equal.
  - Pointer wrap at FIFO_DEPTH must be seamless.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: serial_out=1. If the FIFO is non-empty, pop into an 8-bit shift register, go to START, and clear the baud counter.
  - START: serial_out=0 for N cycles, then go to DATA with bit index 0.
  - DATA: serial_out=shift[0]. At the end of each bit, shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: serial_out=1 for N cycles. At the end: if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle cycles); else go to IDLE.
- Latency: a push at edge k into an empty FIFO with the FSM in IDLE gives the pop at edge k+1. serial_out is low from edge k+1 onward; the start bit spans edges k+1..k+1+N.
- serial_out is driven from a flop (no combinational path from the FSM).
- Push and pop in the same cycle are both honoured; occupancy is unchanged.

Decomposition:
- Shared package/header uart_defs: FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3), UART frame constants (DATA_BITS=8, STOP_BITS=1), and a clog2 function. This package is reused by the receiver.
- One sub-module, uart_tx_fifo:
  - Parameterised on DEPTH and WIDTH=8.
  - Ports: push/din/full, pop/dout/empty.
  - dout is combinational from the read pointer.
  - Same clk/rst_n.

Test Plan:
- Bench overrides CLOCK_FREQ=1000, BAUD_RATE=100, so N=10.
- Reset: rst_n low 3 cycles -> serial_out=1, data_in_ready=1, tx_busy=0. Hold valid=1 during reset -> nothing transmitted after release.
- Single byte 8'hA5 pushed at edge k -> serial_out low edges k+1..k+11, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles. tx_busy falls at edge k+101.
- Back-to-back 8'h00, 8'hFF, 8'h55 pushed on consecutive cycles -> three frames of exactly 100 cycles each with no idle gap. Receiver-model decode matches in order.
- Overflow: push 6 bytes continuously while the first frame starts:
  - Byte 1 is popped, bytes 2-5 fill the FIFO.
  - data_in_ready=0 after byte 5.
  - Byte 6 is held by the producer and accepted one cycle after the byte-2 pop.
  - All 6 bytes are received in order.
- Pointer wrap: push 9 bytes spaced one frame apart -> every byte correct across the two FIFO wraps.
- Mid-frame reset: assert rst_n low during DATA bit 3 of 8'h0F with 2 bytes queued -> serial_out=1 the same cycle. After release: idle line, tx_busy=0, no frames emitted.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART definitions used by the transmitter and the receiver.
//   tx_state_e : frame FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DATA_BITS  : payload bits per frame
//   STOP_BITS  : stop bits per frame
//   clog2()    : ceiling log2 for sizing counters and pointers
package uart_defs;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   // Number of bits needed to count 0..value-1 (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte buffer in front of the UART serialiser.
//   clk, rst_n : core clock, asynchronous active-low reset (empties the buffer)
//   push, din  : write din when push is high and the buffer is not full
//   full       : no free slot
//   pop, dout  : dout shows the oldest entry; pop discards it when not empty
//   empty      : no stored entry
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module uart_tx_fifo
   import uart_defs::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers bytes from the CPU write path and sends each as
// an 8N1 frame (start 0, 8 data bits LSB first, stop 1) at BAUD_RATE.
//   clk, rst_n    : core clock, asynchronous active-low reset
//   data_in       : byte to transmit
//   data_in_valid : producer offers data_in this cycle
//   data_in_ready : buffer can accept a byte (buffer not full)
//   serial_out    : serial line, idle high, driven from a flop
//   tx_busy       : frame in progress or bytes still buffered
//   fsm_state     : current frame FSM state, for observation
//
// Handshake: a byte is taken on a rising clk edge where data_in_valid and
// data_in_ready are both high. data_in_ready depends only on registered
// buffer state, never on data_in_valid; the producer holds data_in and
// data_in_valid steady until the byte is taken.
module uart_transmitter
   import uart_defs::*;
#(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       data_in_valid,
   output logic       data_in_ready,
   output logic       serial_out,
   output logic       tx_busy,
   output tx_state_e  fsm_state
);

   localparam int N     = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   tx_state_e        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shift, shift_n;
   logic             serial_q, serial_n;
   logic             bit_end;

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [7:0]       fifo_dout;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (data_in_valid),
      .din   (data_in),
      .full  (fifo_full),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   assign bit_end       = (cnt == CNT_LAST);
   assign data_in_ready = !fifo_full;
   assign tx_busy       = (state != IDLE) || !fifo_empty;
   assign serial_out    = serial_q;
   assign fsm_state     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         shift    <= '0;
         serial_q <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         shift    <= shift_n;
         serial_q <= serial_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = idx;
      shift_n  = shift;
      fifo_pop = 1'b0;
      serial_n = 1'b1;

      case (state)
         IDLE: begin
            cnt_n = '0;
            idx_n = '0;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_n  = fifo_dout;
               state_n  = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = DATA;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n   = '0;
               shift_n = {1'b0, shift[7:1]};
               idx_n   = idx + 3'd1;
               if (idx == DATA_LAST) begin
                  idx_n   = '0;
                  state_n = STOP;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_n = '0;
               idx_n = idx + 3'd1;
               if (idx == STOP_LAST) begin
                  idx_n = '0;
                  // Chain straight into the next start bit when more bytes wait.
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     shift_n  = fifo_dout;
                     state_n  = START;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // Line level is computed from the next state so the flop shows the
      // new bit in the same cycle the FSM enters it.
      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shift_n[0];
         default: serial_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;
   import uart_defs::*;

   localparam int N     = 10;
   localparam int FRAME = 10 * N;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_in_valid = 1'b0;
   logic       data_in_ready;
   logic       serial_out;
   logic       tx_busy;
   tx_state_e  fsm_state;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] exp_q[$];
   int frames_started = 0;
   int frames_done    = 0;
   int start_cyc[256];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_transmitter #(
      .CLOCK_FREQ (1000),
      .BAUD_RATE  (100),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .serial_out    (serial_out),
      .tx_busy       (tx_busy),
      .fsm_state     (fsm_state)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, required finish before 2000000");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard: line receiver ----------------
   // Samples the line on every falling edge; each frame is checked sample by
   // sample against the byte at the head of exp_q.
   initial begin : monitor
      logic       active;
      int         i;
      int         shape_err;
      logic [9:0] fr;
      logic [7:0] exp_b;
      logic [7:0] rx_b;
      active = 1'b0;
      i = 0;
      shape_err = 0;
      fr = '1;
      exp_b = '0;
      rx_b = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
         end else begin
            if (!active && serial_out === 1'b0) begin
               active = 1'b1;
               i = 0;
               shape_err = 0;
               rx_b = '0;
               if (frames_started < 256) start_cyc[frames_started] = cyc;
               frames_started++;
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                  exp_b = 8'h00;
               end else begin
                  exp_b = exp_q.pop_front();
               end
               fr = {1'b1, exp_b, 1'b0};
            end
            if (active) begin
               if (serial_out !== fr[i / N]) shape_err++;
               if ((i % N) == (N / 2) && (i / N) >= 1 && (i / N) <= 8)
                  rx_b[(i / N) - 1] = serial_out;
               i++;
               if (i == FRAME) begin
                  active = 1'b0;
                  frames_done++;
                  n_tests++;
                  if (shape_err != 0) begin
                     n_fail++;
                     $display("FAIL frame_timing: %0d wrong line samples in frame of 8'h%02h, required 0",
                              shape_err, exp_b);
                  end
                  n_tests++;
                  if (rx_b !== exp_b) begin
                     n_fail++;
                     $display("FAIL rx_byte: got 8'h%02h, required 8'h%02h", rx_b, exp_b);
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offers b until accepted; acc is the edge number of the accepting edge.
   task automatic push_byte(input logic [7:0] b, output int acc);
      logic rdy;
      acc = -1;
      data_in = b;
      data_in_valid = 1'b1;
      for (int w = 0; w < 2000; w++) begin
         rdy = data_in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            acc = cyc;
            exp_q.push_back(b);
            break;
         end
      end
      data_in_valid = 1'b0;
      if (acc < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL push_timeout: byte 8'h%02h not accepted, required acceptance within 2000 cycles", b);
      end
   endtask

   task automatic wait_frames(input int target, input int budget);
      for (int w = 0; w < budget && frames_done < target; w++) tick(1);
      n_tests++;
      if (frames_done < target) begin
         n_fail++;
         $display("FAIL frame_wait: %0d frames completed, required %0d", frames_done, target);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      data_in = 8'h3C;
      data_in_valid = 1'b1;
      tick(3);
      n_tests++;
      if (serial_out !== 1'b1) begin n_fail++; $display("FAIL reset_serial: got %b, required 1", serial_out); end
      n_tests++;
      if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", data_in_ready); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
      n_tests++;
      if (fsm_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", fsm_state); end
      rst_n = 1'b1;
      data_in_valid = 1'b0;
      tick(40);
      n_tests++;
      if (frames_started !== 0) begin n_fail++; $display("FAIL reset_no_tx: %0d frames, required 0", frames_started); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b, required 0", tx_busy); end
   endtask

   task automatic test_single();
      int k;
      int fall;
      int s0;
      int f0;
      s0 = frames_started;
      f0 = frames_done;
      push_byte(8'hA5, k);
      n_tests++;
      if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b, required 1", tx_busy); end
      fall = -1;
      for (int w = 0; w < 300; w++) begin
         tick(1);
         if (tx_busy === 1'b0) begin
            fall = cyc;
            break;
         end
      end
      n_tests++;
      if (fall != k + 101) begin n_fail++; $display("FAIL single_busy_fall: edge %0d, required %0d", fall, k + 101); end
      wait_frames(f0 + 1, 50);
      n_tests++;
      if (start_cyc[s0] != k + 1) begin
         n_fail++;
         $display("FAIL single_latency: start at edge %0d, required %0d", start_cyc[s0], k + 1);
      end
      n_tests++;
      if (serial_out !== 1'b1) begin n_fail++; $display("FAIL single_idle_line: got %b, required 1", serial_out); end
   endtask

   task automatic test_back_to_back();
      int k0, k1, k2;
      int s0;
      int f0;
      s0 = frames_started;
      f0 = frames_done;
      push_byte(8'h00, k0);
      push_byte(8'hFF, k1);
      push_byte(8'h55, k2);
      n_tests++;
      if (k1 != k0 + 1 || k2 != k0 + 2) begin
         n_fail++;
         $display("FAIL b2b_accept: edges %0d,%0d, required %0d,%0d", k1, k2, k0 + 1, k0 + 2);
      end
      wait_frames(f0 + 3, 400);
      for (int j = 0; j < 3; j++) begin
         n_tests++;
         if (start_cyc[s0 + j] != k0 + 1 + j * FRAME) begin
            n_fail++;
            $display("FAIL b2b_gap: frame %0d started at edge %0d, required %0d",
                     j, start_cyc[s0 + j], k0 + 1 + j * FRAME);
         end
      end
   endtask

   task automatic test_overflow();
      int acc[6];
      int f0;
      f0 = frames_done;
      for (int j = 0; j < 5; j++) push_byte(8'($urandom_range(0, 255)), acc[j]);
      n_tests++;
      if (acc[4] != acc[0] + 4) begin
         n_fail++;
         $display("FAIL ovf_fill: byte 5 at edge %0d, required %0d", acc[4], acc[0] + 4);
      end
      n_tests++;
      if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready: got %b, required 0", data_in_ready); end
      push_byte(8'($urandom_range(0, 255)), acc[5]);
      n_tests++;
      if (acc[5] != acc[0] + 102) begin
         n_fail++;
         $display("FAIL ovf_held_accept: byte 6 at edge %0d, required %0d", acc[5], acc[0] + 102);
      end
      wait_frames(f0 + 6, 700);
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d bytes unsent, required 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      int k;
      int s0;
      int f0;
      s0 = frames_started;
      f0 = frames_done;
      for (int j = 0; j < 9; j++) begin
         push_byte(8'($urandom_range(0, 255)), k);
         wait_frames(f0 + j + 1, 150);
         n_tests++;
         if (start_cyc[s0 + j] != k + 1) begin
            n_fail++;
            $display("FAIL wrap_latency: byte %0d started at edge %0d, required %0d", j, start_cyc[s0 + j], k + 1);
         end
         tick(3);
      end
   endtask

   task automatic test_mid_reset();
      int k, k1, k2;
      int s0;
      int f0;
      s0 = frames_started;
      f0 = frames_done;
      push_byte(8'h0F, k);
      push_byte(8'($urandom_range(0, 255)), k1);
      push_byte(8'($urandom_range(0, 255)), k2);
      while (cyc < k + 45) tick(1);
      n_tests++;
      if (fsm_state !== DATA) begin n_fail++; $display("FAIL midrst_in_data: state %0d, required 2", fsm_state); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (serial_out !== 1'b1) begin n_fail++; $display("FAIL midrst_serial: got %b, required 1", serial_out); end
      n_tests++;
      if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, required 0", tx_busy); end
      n_tests++;
      if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", data_in_ready); end
      exp_q.delete();
      tick(3);
      rst_n = 1'b1;
      tick(250);
      n_tests++;
      if (frames_started != s0 + 1 || frames_done != f0) begin
         n_fail++;
         $display("FAIL midrst_no_tx: started %0d done %0d, required %0d and %0d",
                  frames_started, frames_done, s0 + 1, f0);
      end
      n_tests++;
      if (tx_busy !== 1'b0 || serial_out !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_idle: busy %b line %b, required 0 and 1", tx_busy, serial_out);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single();
      tick(5);
      test_back_to_back();
      tick(5);
      test_overflow();
      tick(5);
      test_wrap();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
